// File: rtl/otter_pc_unit.sv
// Program counter for the OTTER MCU: picks the next PC from NUM_SRC candidates and buffers redirects seen during a stall.
// It traps misaligned targets to TRAP_VEC and flags out-of-range select codes instead of loading them.
module otter_pc_unit #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      NUM_SRC   = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  localparam int unsigned     SELW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_SRC*WIDTH-1:0] PC_SRC,
  input  logic [SELW-1:0]          PC_SEL,
  input  logic                     REDIRECT,
  input  logic                     PC_WRITE,
  input  logic [WIDTH-1:0]         TRAP_VEC,
  input  logic                     CLR_ERR,
  output logic [WIDTH-1:0]         PC,
  output logic [WIDTH-1:0]         PC_PLUS4,
  output logic                     PENDING,
  output logic                     MISALIGN,
  output logic                     SEL_ERR
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_t_q, pend_t_d;
  logic             pending_q, pending_d;
  logic             misalign_q, misalign_d;

  logic             sel_ok;
  logic [WIDTH-1:0] mux_t;
  logic [WIDTH-1:0] tgt;
  logic             tgt_vld;
  logic             trap;

  // Widen by one bit so NUM_SRC itself (e.g. 16 with SELW=4) is representable.
  assign sel_ok = ({1'b0, PC_SEL} < (SELW+1)'(NUM_SRC));

  always_comb begin
    mux_t = '0;
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      if (PC_SEL == SELW'(k)) mux_t = PC_SRC[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    pc_d       = pc_q;
    pend_t_d   = pend_t_q;
    pending_d  = pending_q;
    misalign_d = misalign_q;
    trap       = 1'b0;

    // Fresh redirect first, then the buffered one, then an ordinary select.
    tgt_vld = sel_ok || pending_q;
    if (REDIRECT && sel_ok)  tgt = mux_t;
    else if (pending_q)      tgt = pend_t_q;
    else                     tgt = mux_t;

    if (PC_WRITE) begin
      if (tgt_vld) begin
        if (tgt[1:0] != 2'b00) begin
          pc_d = TRAP_VEC;
          trap = 1'b1;
        end else begin
          pc_d = tgt;
        end
        pending_d = 1'b0;
      end
    end else if (REDIRECT && sel_ok) begin
      pend_t_d  = mux_t;
      pending_d = 1'b1;
    end

    if (trap)         misalign_d = 1'b1;
    else if (CLR_ERR) misalign_d = 1'b0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q       <= RESET_VEC;
      pend_t_q   <= '0;
      pending_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pend_t_q   <= pend_t_d;
      pending_q  <= pending_d;
      misalign_q <= misalign_d;
    end
  end

  assign PC       = pc_q;
  assign PC_PLUS4 = pc_q + WIDTH'(4);
  assign PENDING  = pending_q;
  assign MISALIGN = misalign_q;
  assign SEL_ERR  = !sel_ok;

endmodule

// File: tb/tb_otter_pc_unit.sv
// Directed bench for otter_pc_unit: a 4-source unit for the main sequence and a 3-source unit for illegal selects.
module tb_otter_pc_unit;

  logic         clk;
  logic         rst;
  logic [127:0] pc_src;
  logic [1:0]   pc_sel;
  logic         redirect;
  logic         pc_write;
  logic [31:0]  trap_vec;
  logic         clr_err;
  logic [31:0]  pc, pc_plus4;
  logic         pending, misalign, sel_err;

  logic [95:0]  pc_src3;
  logic [1:0]   pc_sel3;
  logic         redirect3;
  logic         pc_write3;
  logic [31:0]  pc3, pc_plus4_3;
  logic         pending3, misalign3, sel_err3;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_pc_q[$];
  logic        exp_pend_q[$];
  logic        exp_mis_q[$];
  string       exp_tag_q[$];

  otter_pc_unit #(.WIDTH(32), .NUM_SRC(4), .RESET_VEC(32'h0)) dut (
    .CLK(clk), .RST(rst), .PC_SRC(pc_src), .PC_SEL(pc_sel), .REDIRECT(redirect),
    .PC_WRITE(pc_write), .TRAP_VEC(trap_vec), .CLR_ERR(clr_err), .PC(pc),
    .PC_PLUS4(pc_plus4), .PENDING(pending), .MISALIGN(misalign), .SEL_ERR(sel_err)
  );

  otter_pc_unit #(.WIDTH(32), .NUM_SRC(3), .RESET_VEC(32'h0)) dut3 (
    .CLK(clk), .RST(rst), .PC_SRC(pc_src3), .PC_SEL(pc_sel3), .REDIRECT(redirect3),
    .PC_WRITE(pc_write3), .TRAP_VEC(trap_vec), .CLR_ERR(clr_err), .PC(pc3),
    .PC_PLUS4(pc_plus4_3), .PENDING(pending3), .MISALIGN(misalign3), .SEL_ERR(sel_err3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "simulation time limit exceeded");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Push the expected post-edge state, let one edge pass, then pop and compare.
  task automatic step(input string tag, input logic [31:0] epc, input logic epend, input logic emis);
    logic [31:0] xpc;
    logic        xpend, xmis;
    string       xtag;
    exp_pc_q.push_back(epc);
    exp_pend_q.push_back(epend);
    exp_mis_q.push_back(emis);
    exp_tag_q.push_back(tag);
    @(posedge clk);
    #1;
    xpc   = exp_pc_q.pop_front();
    xpend = exp_pend_q.pop_front();
    xmis  = exp_mis_q.pop_front();
    xtag  = exp_tag_q.pop_front();
    chk({xtag, ".pc"}, pc, xpc);
    chk({xtag, ".pending"}, {31'b0, pending}, {31'b0, xpend});
    chk({xtag, ".misalign"}, {31'b0, misalign}, {31'b0, xmis});
  endtask

  task automatic set_src(input int k, input logic [31:0] v);
    pc_src[k*32 +: 32] = v;
  endtask

  initial begin
    rst = 1'b1; pc_src = '0; pc_sel = 2'd0; redirect = 1'b0; pc_write = 1'b1;
    trap_vec = 32'h80; clr_err = 1'b0;
    pc_src3 = '0; pc_sel3 = 2'd0; redirect3 = 1'b0; pc_write3 = 1'b0;
    set_src(0, 32'h4);

    // Reset held with writes enabled keeps PC at the reset vector.
    for (int i = 0; i < 3; i++) step("reset_hold", 32'h0, 1'b0, 1'b0);
    chk("reset_plus4", pc_plus4, 32'h4);
    rst = 1'b0;

    // Sequential fetch.
    set_src(0, 32'h4);  step("seq0", 32'h4, 1'b0, 1'b0);
    set_src(0, 32'h8);  step("seq1", 32'h8, 1'b0, 1'b0);
    set_src(0, 32'hC);  step("seq2", 32'hC, 1'b0, 1'b0);
    chk("plus4_seq", pc_plus4, 32'h10);
    pc_sel = 2'd2; set_src(2, 32'h100); step("sel2", 32'h100, 1'b0, 1'b0);

    // Stalled redirect survives later non-redirect stall cycles.
    pc_write = 1'b0; redirect = 1'b1; pc_sel = 2'd1; set_src(1, 32'h200);
    step("stall_redir", 32'h100, 1'b1, 1'b0);
    redirect = 1'b0; pc_sel = 2'd0; set_src(0, 32'h104);
    for (int i = 0; i < 3; i++) step("stall_hold", 32'h100, 1'b1, 1'b0);
    pc_write = 1'b1; step("pend_commit", 32'h200, 1'b0, 1'b0);

    // Newest stalled redirect wins.
    pc_write = 1'b0; redirect = 1'b1; pc_sel = 2'd1; set_src(1, 32'h200);
    step("ovw_a", 32'h200, 1'b1, 1'b0);
    set_src(1, 32'h300); step("ovw_b", 32'h200, 1'b1, 1'b0);
    pc_write = 1'b1; redirect = 1'b0; pc_sel = 2'd0; set_src(0, 32'h204);
    step("ovw_commit", 32'h300, 1'b0, 1'b0);

    // Fresh redirect beats a pending one.
    pc_write = 1'b0; redirect = 1'b1; pc_sel = 2'd1; set_src(1, 32'h300);
    step("prio_stall", 32'h300, 1'b1, 1'b0);
    pc_write = 1'b1; pc_sel = 2'd2; set_src(2, 32'h400);
    step("prio_fresh", 32'h400, 1'b0, 1'b0);
    redirect = 1'b0;

    // Misaligned target traps; clear; trap with simultaneous clear stays set.
    set_src(2, 32'h202); step("mis_trap", 32'h80, 1'b0, 1'b1);
    pc_write = 1'b0; clr_err = 1'b1; step("mis_clr", 32'h80, 1'b0, 1'b0);
    pc_write = 1'b1; step("mis_trap_clr", 32'h80, 1'b0, 1'b1);
    pc_write = 1'b0; step("mis_clr2", 32'h80, 1'b0, 1'b0);
    clr_err = 1'b0;

    // Pending target is checked for alignment as well.
    redirect = 1'b1; pc_sel = 2'd1; set_src(1, 32'h206); trap_vec = 32'h90;
    step("mis_pend_stall", 32'h80, 1'b1, 1'b0);
    redirect = 1'b0; pc_write = 1'b1; pc_sel = 2'd0; set_src(0, 32'h500);
    step("mis_pend_trap", 32'h90, 1'b0, 1'b1);
    pc_write = 1'b0; clr_err = 1'b1; step("mis_clr3", 32'h90, 1'b0, 1'b0);
    clr_err = 1'b0;

    // Asynchronous reset mid-stall with a pending redirect.
    redirect = 1'b1; pc_sel = 2'd1; set_src(1, 32'h600);
    step("rst_pend", 32'h90, 1'b1, 1'b0);
    redirect = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pending", {31'b0, pending}, 32'h0);
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_plus4", pc_plus4, 32'h4);
    @(posedge clk); #1;
    rst = 1'b0;

    // PC_PLUS4 wraps at the top of the address space.
    pc_write = 1'b1; pc_sel = 2'd0; set_src(0, 32'hFFFF_FFFC);
    step("wrap_load", 32'hFFFF_FFFC, 1'b0, 1'b0);
    chk("wrap_plus4", pc_plus4, 32'h0);
    chk("sel_err_4src", {31'b0, sel_err}, 32'h0);
    pc_write = 1'b0;

    // Three-source unit: illegal select is flagged and ignored.
    pc_write3 = 1'b1; pc_sel3 = 2'd0; pc_src3[0 +: 32] = 32'h40;
    step("dut3_load", 32'hFFFF_FFFC, 1'b0, 1'b0);
    chk("dut3_pc_load", pc3, 32'h40);
    pc_write3 = 1'b0; redirect3 = 1'b1; pc_sel3 = 2'd1; pc_src3[32 +: 32] = 32'h44;
    step("dut3_stall", 32'hFFFF_FFFC, 1'b0, 1'b0);
    chk("dut3_pend_set", {31'b0, pending3}, 32'h1);
    pc_write3 = 1'b1; pc_sel3 = 2'd3;
    #1;
    chk("dut3_sel_err", {31'b0, sel_err3}, 32'h1);
    step("dut3_illegal", 32'hFFFF_FFFC, 1'b0, 1'b0);
    chk("dut3_pc_hold_pending_used", pc3, 32'h44);
    chk("dut3_pend_clear", {31'b0, pending3}, 32'h0);
    step("dut3_illegal2", 32'hFFFF_FFFC, 1'b0, 1'b0);
    chk("dut3_pc_hold", pc3, 32'h44);
    chk("dut3_pend_unchanged", {31'b0, pending3}, 32'h0);
    chk("dut3_sel_err2", {31'b0, sel_err3}, 32'h1);
    pc_sel3 = 2'd2; redirect3 = 1'b0; pc_write3 = 1'b0;
    #1;
    chk("dut3_sel_ok", {31'b0, sel_err3}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/otter_pc_unit.md
# otter_pc_unit

Parametrised program-counter unit for the OTTER MCU: selects the next PC from NUM_SRC candidate addresses, holds it in a registered PC, and buffers a redirect that arrives while the fetch stage is stalled. It also traps misaligned targets and reports illegal select codes instead of loading a garbage address. It sits between the branch/jump address generators and instruction memory, replacing the fixed 4-way combinational select plus separate PC register.

## Interface

Parameters:
- WIDTH, 32, address width; must be ≥ 3.
- NUM_SRC, 4, number of candidate sources; 2 to 16.
- RESET_VEC, 32'h0000_0000, PC value after reset.
- SELW, max(1, $clog2(NUM_SRC)), select width; derived, not overridden.

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-high reset.
- PC_SRC  in  NUM_SRC*WIDTH  candidate k at bits [k*WIDTH +: WIDTH].
- PC_SEL  in  SELW  candidate index.
- REDIRECT  in  1  current PC_SEL names a control-flow redirect that must not be lost.
- PC_WRITE  in  1  advance PC this cycle; low = stall.
- TRAP_VEC  in  WIDTH  load address on a misaligned target.
- CLR_ERR  in  1  clears MISALIGN.
- PC  out  WIDTH  current PC, registered.
- PC_PLUS4  out  WIDTH  PC + 4, combinational, modulo 2^WIDTH.
- PENDING  out  1  a buffered redirect is held.
- MISALIGN  out  1  sticky misaligned-target flag.
- SEL_ERR  out  1  PC_SEL ≥ NUM_SRC this cycle, combinational.

## Operation

- Selection:
  - sel_ok = (PC_SEL < NUM_SRC).
  - mux_t = PC_SRC[PC_SEL] when sel_ok.
  - SEL_ERR = !sel_ok.
- Target: T = (REDIRECT && sel_ok) ? mux_t : PENDING ? pend_t : sel_ok ? mux_t : (none).
  - A fresh redirect beats a buffered one.
  - A buffered redirect beats a non-redirect select.
- PC_WRITE=1 with a valid T:
  - If T[1:0] != 2'b00: PC <= TRAP_VEC and MISALIGN <= 1.
  - Otherwise PC <= T.
  - PENDING <= 0.
- PC_WRITE=1 with no valid T (SEL_ERR and no pending): PC holds, PENDING unchanged.
- PC_WRITE=0 with REDIRECT=1 and sel_ok:
  - pend_t <= mux_t, PENDING <= 1.
  - Overwrites any older pending target; the newest redirect wins.
- PC_WRITE=0 otherwise: PC, pend_t and PENDING hold.
- REDIRECT=1 with SEL_ERR: the redirect is ignored, nothing is captured, and SEL_ERR is asserted.
- MISALIGN:
  - Set on a trapped write.
  - Cleared by CLR_ERR when no trap occurs the same cycle; a set and a clear in the same cycle leave MISALIGN = 1.
- The misalign check applies to the pending target too.
- TRAP_VEC itself is not checked.
- Arithmetic: PC_PLUS4 wraps, e.g. all-ones - 3 + 4 = 0.
- No state machine beyond PENDING (IDLE / HELD):
  - IDLE -> HELD on a stalled redirect.
  - HELD -> IDLE on PC_WRITE with a valid target.

## Timing

- Reset (asynchronous, any cycle, including mid-stall with PENDING=1):
  - PC = RESET_VEC, pend_t = 0, PENDING = 0, MISALIGN = 0.
  - PC_PLUS4 = RESET_VEC + 4.
- Release: first update on the first rising CLK edge after RST deasserts.
- Latency:
  - Select to PC: 1 cycle (PC valid after the edge at which PC_WRITE=1).
  - PC to PC_PLUS4: 0 cycles.
  - SEL_ERR: same cycle as PC_SEL.
- Stall buffering: a redirect seen in any stalled cycle is committed on the first later edge with PC_WRITE=1, unless replaced by a newer redirect.
- Simultaneous REDIRECT, PC_WRITE and PENDING: the fresh target is loaded and the pending one is discarded.

## Test plan

- Reset: hold RST with PC_WRITE=1 and CLK running -> PC = RESET_VEC every cycle. Assert RST mid-stall with PENDING=1 -> PENDING = 0 immediately, without a clock edge.
- Sequential select: NUM_SRC=4, src0=PC+4, PC_SEL=0, PC_WRITE=1 for 3 cycles from 0 -> PC = 4, 8, 12. PC_SEL=2 with src2=0x100 -> PC = 0x100 next cycle.
- Stalled redirect:
  - PC_WRITE=0, REDIRECT=1, src1=0x200 for one cycle -> PENDING = 1.
  - Stall 3 more cycles with PC_SEL=0 -> PC unchanged.
  - Then PC_WRITE=1 -> PC = 0x200, PENDING = 0.
- Overwrite and priority: stalled redirects to 0x200 then 0x300 -> load gives 0x300. With pending 0x300, PC_WRITE=1, REDIRECT=1 to 0x400 -> PC = 0x400.
- Misalign: PC_WRITE=1 to target 0x202, TRAP_VEC=0x80 -> PC = 0x80, MISALIGN = 1. CLR_ERR for one cycle -> MISALIGN = 0. Trap and CLR_ERR in the same cycle -> MISALIGN = 1.
- Illegal select: NUM_SRC=3, PC_SEL=3, PC_WRITE=1, REDIRECT=1 -> SEL_ERR = 1, PC holds, PENDING unchanged. PC=0xFFFF_FFFC -> PC_PLUS4 = 0.
